// File: rtl/ram_pkg.sv
// Shared constants and word/address types for the 256x8 scratch RAM.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_DEPTH      = 256;

    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;

endpackage : ram_pkg

// File: rtl/ram_word_reg.sv
// One storage word: a register with asynchronous clear and a load enable.
module ram_word_reg #(
    parameter int WIDTH = ram_pkg::RAM_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Clear at once on reset; otherwise capture d when this word is selected for a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : ram_word_reg

// File: rtl/ram_256x8.sv
// Single-port 256x8 register-file RAM: synchronous write, combinational read,
// asynchronous clear of the whole array. Built from flip-flops (not block RAM)
// because every word must clear on reset and reads have zero latency.
module ram_256x8
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Current content of every word, driven by the word registers.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write decoder and storage: exactly one word loads when wr is high.
    // Reset overrides the load inside each word, so writes during reset are dropped.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic load_sel;

            // Decode: this word is the write target.
            assign load_sel = wr && (addr == ADDR_WIDTH'(gi));

            ram_word_reg #(
                .WIDTH (DATA_WIDTH)
            ) u_word (
                .clk   (clk),
                .reset (reset),
                .load  (load_sel),
                .d     (wdata),
                .q     (mem[gi])
            );
        end
    endgenerate

    // Read mux: no bypass of wdata, so a same-address write shows only after the edge.
    assign rdata = mem[addr];

endmodule : ram_256x8

// File: tb/tb_ram_256x8.sv
// Self-checking bench for ram_256x8: directed plan plus random traffic,
// scored against a plain array model through an expectation queue.
module tb_ram_256x8;

    logic       clk;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic [7:0] rdata;

    ram_256x8 dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .wr    (wr),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each address should hold.
    logic [7:0] model [256];

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: whenever an expectation is queued, sample rdata and compare.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e.exp) begin
                errors++;
                $display("FAIL %s addr=%02h rdata=%02h expected=%02h", e.name, e.a, rdata, e.exp);
            end else begin
                $display("chk %s addr=%02h rdata=%02h ok", e.name, e.a, rdata);
            end
        end
    end

    // Let inputs settle, queue the expectation, wait (bounded) for the monitor.
    task automatic chk(input string name, input logic [7:0] expv);
        exp_t e;
        int   t;
        #1;
        e.name = name;
        e.a    = addr;
        e.exp  = expv;
        exp_q.push_back(e);
        t = 0;
        while (exp_q.size() != 0 && t < 3) begin
            #0.1;
            t++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s monitor timeout addr=%02h rdata=%02h expected=%02h", name, addr, rdata, expv);
            exp_q.delete();
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
    endtask

    // One write on the next edge; wr is left high so calls chain on consecutive edges.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        if (!reset) model[a] = d;
    endtask

    task automatic read_at(input string name, input logic [7:0] a);
        @(negedge clk);
        wr   = 1'b0;
        addr = a;
        chk(name, model[a]);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rd;
        logic       rw;

        addr  = 8'h00;
        wdata = 8'h00;
        wr    = 1'b0;
        reset = 1'b1;
        model_clear();

        // 1. Reset clears the array.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) read_at("reset_sweep", 8'(i));

        // 2. Basic write/read on consecutive edges.
        do_write(8'h00, 8'h00);
        do_write(8'h01, 8'h55);
        do_write(8'h02, 8'h56);
        read_at("basic_a1", 8'h01);
        read_at("basic_a2", 8'h02);
        read_at("basic_a0", 8'h00);

        // 3. Read-during-write shows old data before the edge, new data after.
        @(negedge clk);
        addr  = 8'h03;
        wdata = 8'hA5;
        wr    = 1'b1;
        chk("rdw_before", model[3]);
        @(posedge clk);
        model[3] = 8'hA5;
        chk("rdw_after", model[3]);
        wr   = 1'b0;
        addr = 8'h01;
        chk("comb_addr_change", model[1]);

        // 4. Write inhibit, then overwrite with last-write-wins.
        @(negedge clk);
        addr  = 8'h02;
        wdata = 8'hFF;
        wr    = 1'b0;
        repeat (3) @(posedge clk);
        chk("inhibit_a2", model[2]);
        do_write(8'h02, 8'h11);
        do_write(8'h02, 8'h22);
        read_at("overwrite_a2", 8'h02);

        // Random traffic: check before the edge, then after a possible write.
        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            rw = 1'($urandom_range(0, 1));
            @(negedge clk);
            addr  = ra;
            wdata = rd;
            wr    = rw;
            chk("rand_pre", model[ra]);
            @(posedge clk);
            if (rw) model[ra] = rd;
            chk("rand_post", model[ra]);
        end

        // 5. Full-sweep write of addr^3C, then read back everything.
        for (int i = 0; i < 256; i++) do_write(8'(i), 8'(i) ^ 8'h3C);
        for (int i = 0; i < 256; i++) read_at("sweep", 8'(i));
        read_at("bound_ff", 8'hFF);
        chk("bound_ff_const", 8'hC3);
        read_at("bound_00", 8'h00);
        chk("bound_00_const", 8'h3C);

        // 6a. Short async reset pulse between edges clears at once.
        @(negedge clk);
        addr = 8'hFF;
        chk("pre_pulse", model[8'hFF]);
        reset = 1'b1;
        model_clear();
        chk("async_pulse", 8'h00);
        reset = 1'b0;

        // 6b. Write attempted while reset is held is ignored.
        @(negedge clk);
        reset = 1'b1;
        addr  = 8'h05;
        wdata = 8'h77;
        wr    = 1'b1;
        @(posedge clk);
        chk("wr_in_reset", 8'h00);
        @(negedge clk);
        reset = 1'b0;
        wr    = 1'b0;
        chk("after_release_a5", model[5]);
        for (int n = 0; n < 16; n++) read_at("post_reset", 8'($urandom_range(0, 255)));

        // Writes work again after release.
        do_write(8'h05, 8'h9A);
        read_at("post_release_write", 8'h05);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ram_256x8
